// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, op encodings and FSM states for the RV32M divider
package div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(XLEN - 1);

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } divState_t;

  // Two's-complement magnitude; 0x80000000 maps onto itself, read as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value, input logic isSigned);
    return (isSigned && value[XLEN-1]) ? (~value + XLEN'(1)) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] remIn,
  input  logic            dividendBit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remOut,
  output logic            quotientBit
);

  logic [XLEN:0] shifted;

  // The shifted remainder needs one extra bit; after a successful subtract it fits in XLEN again.
  always_comb begin
    shifted     = {remIn, dividendBit};
    quotientBit = (shifted >= {1'b0, divisor});
    remOut      = quotientBit ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative DIV/DIVU/REM/REMU unit; define DIV_FASTPATH_EN to skip CALC
// for divide-by-zero, signed overflow and divisor of one.
module div_unit
  import div_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  divState_t        state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  divisorMag;
  logic [XLEN-1:0]  rs1Reg;
  logic [XLEN-1:0]  rs2Reg;
  logic [1:0]       opReg;
  logic [4:0]       rdReg;

  logic            accept;
  logic            inSigned;
  logic [XLEN-1:0] stepRem;
  logic            stepQ;
  logic            regSigned;
  logic            overflow;
  logic [XLEN-1:0] quoFix;
  logic [XLEN-1:0] remFix;
  logic [XLEN-1:0] fixResult;

  assign ready_o  = (state == IDLE);
  assign valid_o  = (state == DONE);
  assign accept   = valid_i & ready_o;
  assign inSigned = ~op_i[0];

`ifdef DIV_FASTPATH_EN
  logic fastCase;
  assign fastCase = (rs2_data_i == '0) || (rs2_data_i == XLEN'(1)) ||
                    (inSigned && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1));
`endif

  div_step uStep (
    .remIn      (rem),
    .dividendBit(quo[XLEN-1]),
    .divisor    (divisorMag),
    .remOut     (stepRem),
    .quotientBit(stepQ)
  );

  // Sign correction and the architecturally defined special cases, all from captured operands.
  always_comb begin
    regSigned = ~opReg[0];
    overflow  = regSigned && (rs1Reg == {1'b1, {(XLEN-1){1'b0}}}) && (rs2Reg == '1);
    quoFix    = (regSigned && (rs1Reg[XLEN-1] ^ rs2Reg[XLEN-1])) ? (~quo + XLEN'(1)) : quo;
    remFix    = (regSigned && rs1Reg[XLEN-1]) ? (~rem + XLEN'(1)) : rem;
    if (rs2Reg == '0) begin
      quoFix = '1;
      remFix = rs1Reg;
    end else if (overflow) begin
      quoFix = {1'b1, {(XLEN-1){1'b0}}};
      remFix = '0;
    end else if (rs2Reg == XLEN'(1)) begin
      quoFix = rs1Reg;
      remFix = '0;
    end
    fixResult = opReg[1] ? remFix : quoFix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= '0;
      quo        <= '0;
      rem        <= '0;
      divisorMag <= '0;
      rs1Reg     <= '0;
      rs2Reg     <= '0;
      opReg      <= '0;
      rdReg      <= '0;
      result_o   <= '0;
      rd_o       <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo        <= magnitude(rs1_data_i, inSigned);
            divisorMag <= magnitude(rs2_data_i, inSigned);
            rem        <= '0;
            rs1Reg     <= rs1_data_i;
            rs2Reg     <= rs2_data_i;
            opReg      <= op_i;
            rdReg      <= rd_i;
            count      <= '0;
`ifdef DIV_FASTPATH_EN
            state      <= fastCase ? FIX : CALC;
`else
            state      <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= stepRem;
          quo <= {quo[XLEN-2:0], stepQ};
          if (count == LAST_COUNT) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        FIX: begin
          result_o <= fixResult;
          rd_o     <= rdReg;
          state    <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
